orangecrab_reset_request: RTL and testbench
===========================================

# orangecrab_reset_request

Generates the `do_reset` request consumed by the board-reset driver from the OrangeCrab user button. Synchronizes the asynchronous active-low button, debounces it, requires a sustained long press, and fires only on button release. Firing on release avoids asserting reset while the button is still held, which would otherwise collide with the bootloader's button-at-power-up entry. Sits in the top level between the `btn_n` pad and the reset driver's `do_reset` input.

## Interface
- `DEBOUNCE_CYCLES`, default 480000 (10 ms at 48 MHz): continuous-press cycles before a press is accepted; must be ≥ 2.
- `HOLD_CYCLES`, default 96000000 (2 s at 48 MHz): further continuous-press cycles before the request arms; must be ≥ 2.

Ports:
- `clk` — input, 1: the only clock.
- `rst` — input, 1: asynchronous, active-high reset.
- `btn_n` — input, 1: raw button, active-low, asynchronous to `clk`.
- `holding` — output, 1: high in HOLD and ARMED; drives the progress LED.
- `armed` — output, 1: high in ARMED only.
- `do_reset` — output, 1: reset request; sticky once asserted.
- `sw_req` — input, 1: present only with `ORANGECRAB_RESET_REQ_SW_EN`; single-cycle software request.

## Operation
- **Synchronizer:** 2-flop chain on `btn_n`, reset to 1 (released). `pressed = ~btn_s`.
- **Counter:**
  - One shared counter, width `$clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES))`.
  - Cleared on every state transition.
  - Increments each cycle in DEBOUNCE and HOLD; never wraps.
- **FSM states:** IDLE, DEBOUNCE, HOLD, ARMED, FIRE.
  - IDLE: if `pressed` → DEBOUNCE.
  - DEBOUNCE:
    - if `!pressed` → IDLE.
    - else if count == DEBOUNCE_CYCLES−1 → HOLD.
  - HOLD:
    - if `!pressed` → IDLE (abort, no request).
    - else if count == HOLD_CYCLES−1 → ARMED.
  - ARMED: if `!pressed` → FIRE. There is no timeout; the FSM stays here while the button is held.
  - FIRE: terminal. Leaves only on `rst`.
- **Outputs:** registered and decoded from the state register. `do_reset` is 1 in FIRE only, and is therefore sticky.
- **Reset:** `rst` at any point (including mid-HOLD or in FIRE) forces IDLE, counter 0, synchronizer 1,1, and all outputs 0 on the same edge, asynchronously.
- **Glitches:** a release of a single synchronized cycle during DEBOUNCE or HOLD aborts to IDLE, and counting restarts from zero.

## Timing
- Reset values: `holding` = 0, `armed` = 0, `do_reset` = 0, state IDLE.
- Synchronizer latency: 2 cycles from a `btn_n` edge to `btn_s`.
- The state changes on the cycle after the condition is sampled. The outputs follow the state with no extra delay.
- Press to `holding` = 1: 2 (sync) + 1 (enter DEBOUNCE) + DEBOUNCE_CYCLES cycles.
- `holding` to `armed`: HOLD_CYCLES cycles.
- Release to `do_reset` = 1: 2 (sync) + 1 cycles.
- Simultaneous events: `rst` has highest priority. `sw_req`, when compiled in, beats the button in every state.

## Configuration
- `ORANGECRAB_RESET_REQ_SW_EN` defined:
  - The `sw_req` port exists.
  - `sw_req` = 1 in IDLE, DEBOUNCE, HOLD or ARMED → FIRE on the next edge, regardless of `pressed`.
  - `sw_req` is ignored in FIRE.
- Undefined: the port and its logic are absent; the button is the only request source.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=16.
- **Reset values:** `rst` pulse with `btn_n`=1 → all outputs 0. Idle 100 cycles → `do_reset` stays 0.
- **Full press:**
  - Stimulus: `btn_n`=0 for 40 cycles, then 1.
  - Required: `holding` rises 7 cycles after the press edge; `armed` rises 16 cycles later; `do_reset` rises 3 cycles after release and stays 1 for 50 more cycles.
- **Short press:** `btn_n`=0 for 3 cycles, then 1 → `holding` never rises; `do_reset` = 0.
- **Early abort:** release with 10 cycles of HOLD elapsed → `holding` falls 3 cycles later. A re-press restarts the full 7+16 sequence.
- **Reset mid-operation:** assert `rst` while ARMED → all outputs 0 immediately. After `rst` deasserts, a release produces no `do_reset`.
- **SW request (with `ORANGECRAB_RESET_REQ_SW_EN`):** pulse `sw_req` in IDLE → `do_reset` = 1 on the next edge. Without the macro, the bench verifies the port is absent.

Source files
------------

// File: rtl/orangecrab_reset_request.sv
`default_nettype none
// ============================================================================
//  Module   : orangecrab_reset_request
//  Purpose  : Turns a sustained long press of the OrangeCrab user button into
//             a sticky board-reset request. The request fires on button
//             release, never while the button is held, so it cannot collide
//             with the bootloader's button-at-power-up entry.
//  Ports    : clk      - sole clock
//             rst      - asynchronous active-high reset
//             btn_n    - raw active-low button, asynchronous to clk
//             holding  - high while the long press is in progress or armed
//             armed    - high once the press is long enough to fire
//             do_reset - sticky reset request to the board-reset driver
//             sw_req   - single-cycle software request; this port exists only
//                        when ORANGECRAB_RESET_REQ_SW_EN is defined
//  Config   : ORANGECRAB_RESET_REQ_SW_EN - adds the sw_req source, which beats
//             the button in every state except FIRE
//  Revision : 1.0 - initial release
// ============================================================================
module orangecrab_reset_request #(
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int HOLD_CYCLES     = 96000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic holding,
    output logic armed,
    output logic do_reset
`ifdef ORANGECRAB_RESET_REQ_SW_EN
    ,
    input  logic sw_req
`endif
);

    // One counter serves both timed phases, so it is sized for the longer one.
    localparam int c_MAX_CYCLES = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0] c_DEB_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_HOLD     = 3'd2,
        ST_ARMED    = 3'd3,
        ST_FIRE     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic                 btn_meta_q;
    logic                 btn_s_q;
    logic                 holding_q;
    logic                 armed_q;
    logic                 do_reset_q;
    logic                 w_pressed;
    logic                 w_sw_req;

`ifdef ORANGECRAB_RESET_REQ_SW_EN
    assign w_sw_req = sw_req;
`else
    assign w_sw_req = 1'b0;
`endif

    // Two-flop synchronizer; resets to the released level so a reset never
    // looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 1'b1;
            btn_s_q    <= 1'b1;
        end else begin
            btn_meta_q <= btn_n;
            btn_s_q    <= btn_meta_q;
        end
    end

    assign w_pressed = ~btn_s_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                if (w_pressed) begin
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!w_pressed) begin
                    state_d = ST_IDLE;
                end else if (count_q == c_DEB_LAST) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Releasing before the hold time expires aborts silently.
                if (!w_pressed) begin
                    state_d = ST_IDLE;
                end else if (count_q == c_HOLD_LAST) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // No timeout: fire only once the button is let go.
                if (!w_pressed) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_d = ST_FIRE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Software request overrides the button everywhere except FIRE.
        if (w_sw_req && (state_q != ST_FIRE)) begin
            state_d = ST_FIRE;
        end

        // Every transition restarts timing; within a timed phase the counter
        // saturates rather than wrapping.
        if (state_d != state_q) begin
            count_d = '0;
        end else if (((state_q == ST_DEBOUNCE) || (state_q == ST_HOLD)) && (count_q != '1)) begin
            count_d = count_q + c_CNT_ONE;
        end
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they change on the same edge as the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            holding_q  <= 1'b0;
            armed_q    <= 1'b0;
            do_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            holding_q  <= (state_d == ST_HOLD) || (state_d == ST_ARMED);
            armed_q    <= (state_d == ST_ARMED);
            do_reset_q <= (state_d == ST_FIRE);
        end
    end

    assign holding  = holding_q;
    assign armed    = armed_q;
    assign do_reset = do_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_orangecrab_reset_request.sv
`default_nettype none
// ============================================================================
//  Module   : tb_orangecrab_reset_request
//  Purpose  : Self-checking bench for orangecrab_reset_request with
//             DEBOUNCE_CYCLES=4, HOLD_CYCLES=16. Expected outputs come from a
//             press-run-length reference model and are queued per cycle; a
//             monitor compares them on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_orangecrab_reset_request;

    localparam int c_DEB  = 4;
    localparam int c_HOLD = 16;

    logic clk = 1'b0;
    logic rst;
    logic btn_n;
    logic sw_drv;
    wire  holding;
    wire  armed;
    wire  do_reset;

    orangecrab_reset_request #(
        .DEBOUNCE_CYCLES (c_DEB),
        .HOLD_CYCLES     (c_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (btn_n),
        .holding  (holding),
        .armed    (armed),
        .do_reset (do_reset)
`ifdef ORANGECRAB_RESET_REQ_SW_EN
        ,
        .sw_req   (sw_drv)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a two-deep delay line for the synchronizer, the length
    // of the current synchronized press run, and a sticky fired flag.
    logic       m_dly[$];
    int         m_run;
    bit         m_fired;
    logic [2:0] exp_q[$];

    function automatic void model_reset();
        m_dly   = '{1'b1, 1'b1};
        m_run   = 0;
        m_fired = 1'b0;
    endfunction

    // Called at each rising edge with the inputs that were held during the
    // cycle that just ended.
    function automatic void model_step(input logic b, input logic s);
        bit p;
        bit was_armed;
        p         = ~m_dly.pop_front();
        m_dly.push_back(b);
        was_armed = !m_fired && (m_run >= c_DEB + c_HOLD + 1);
`ifdef ORANGECRAB_RESET_REQ_SW_EN
        if (s) m_fired = 1'b1;
`else
        if (s) m_fired = m_fired;
`endif
        if (was_armed && !p) m_fired = 1'b1;
        m_run = p ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
        exp_q.push_back({!m_fired && (m_run >= c_DEB + 1),
                         !m_fired && (m_run >= c_DEB + c_HOLD + 1),
                         m_fired});
    endfunction

    task automatic cyc(input logic b, input logic s);
        btn_n  = b;
        sw_drv = s;
        @(posedge clk);
        model_step(b, s);
        #1;
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) cyc(b, 1'b0);
    endtask

    // Asynchronous reset: outputs must drop immediately, before any edge.
    task automatic apply_rst();
        rst = 1'b1;
        exp_q.delete();
        #1;
        n_vec++;
        if ({holding, armed, do_reset} !== 3'b000) begin
            n_err++;
            $display("FAIL async_rst: got h/a/d=%b required 000 at %0t",
                     {holding, armed, do_reset}, $time);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({holding, armed, do_reset} !== e) begin
                n_err++;
                $display("FAIL outputs: got h/a/d=%b required %b at %0t",
                         {holding, armed, do_reset}, e, $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        btn_n  = 1'b1;
        sw_drv = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_vec++;
        if ({holding, armed, do_reset} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_values: got h/a/d=%b required 000",
                     {holding, armed, do_reset});
        end
        rst = 1'b0;

        // Idle: nothing may fire.
        hold(1'b1, 100);

        // Full press then release; do_reset must stay up.
        hold(1'b0, 40);
        hold(1'b1, 60);
        apply_rst();

        // Short press.
        hold(1'b0, 3);
        hold(1'b1, 20);

        // Early abort with 10 HOLD cycles elapsed, then a full re-press.
        hold(1'b0, 17);
        hold(1'b1, 10);
        hold(1'b0, 30);
        hold(1'b1, 10);
        apply_rst();

        // Reset while ARMED, then release: no request.
        hold(1'b0, 30);
        apply_rst();
        hold(1'b0, 3);
        hold(1'b1, 20);

        // Single-cycle glitch during counting restarts the count.
        hold(1'b0, 10);
        hold(1'b1, 1);
        hold(1'b0, 10);
        hold(1'b1, 5);

        // Boundaries: one short of / exactly the debounce and arm thresholds.
        hold(1'b0, c_DEB);
        hold(1'b1, 6);
        hold(1'b0, c_DEB + 1);
        hold(1'b1, 6);
        hold(1'b0, c_DEB + c_HOLD);
        hold(1'b1, 8);
        hold(1'b0, c_DEB + c_HOLD + 1);
        hold(1'b1, 8);
        apply_rst();

`ifdef ORANGECRAB_RESET_REQ_SW_EN
        // Software request in IDLE, during HOLD, and ignored once fired.
        cyc(1'b1, 1'b1);
        hold(1'b1, 5);
        apply_rst();
        hold(1'b0, 12);
        cyc(1'b0, 1'b1);
        hold(1'b0, 5);
        cyc(1'b1, 1'b1);
        hold(1'b1, 5);
        apply_rst();
`else
        $display("note: sw_req port not compiled in");
`endif

        // Randomized presses, releases, resets and software pulses.
        for (int i = 0; i < 60; i++) begin
            int plen;
            int rlen;
            plen = int'($urandom_range(1, 30));
            rlen = int'($urandom_range(1, 8));
            for (int k = 0; k < plen; k++) begin
`ifdef ORANGECRAB_RESET_REQ_SW_EN
                cyc(1'b0, ($urandom_range(0, 99) == 0));
`else
                cyc(1'b0, 1'b0);
`endif
            end
            hold(1'b1, rlen);
            if (m_fired || ($urandom_range(0, 9) == 0)) apply_rst();
        end

        hold(1'b1, 3);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
